// File: rtl/gpu_pkg.sv
// Shared GPU core types: core FSM states, fetcher states and program memory geometry.
package gpu_pkg;

    localparam int PROGRAM_MEM_ADDR_BITS = 8;
    localparam int PROGRAM_MEM_DATA_BITS = 16;

    typedef enum logic [2:0] {
        CORE_FETCH  = 3'b001,
        CORE_DECODE = 3'b010
    } core_state_t;

    typedef enum logic [2:0] {
        FETCH_IDLE     = 3'b000,
        FETCH_FETCHING = 3'b001,
        FETCH_FETCHED  = 3'b010
    } fetcher_state_t;

endpackage

// File: rtl/fetch_icache.sv
// Direct-mapped instruction cache: combinational lookup, registered fill and bulk invalidate.
module fetch_icache #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16,
    parameter int DEPTH     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] lookup_pc,
    input  logic                 fill_en,
    input  logic [ADDR_BITS-1:0] fill_pc,
    input  logic [DATA_BITS-1:0] fill_data,
    input  logic                 invalidate,
    output logic                 hit,
    output logic [DATA_BITS-1:0] hit_data
);

    localparam int IDX_BITS = $clog2(DEPTH);
    localparam int TAG_BITS = ADDR_BITS - IDX_BITS;

    logic [DEPTH-1:0]     valid;
    logic [TAG_BITS-1:0]  tags  [DEPTH];
    logic [DATA_BITS-1:0] lines [DEPTH];

    logic [IDX_BITS-1:0]  lk_idx, fl_idx;
    logic [TAG_BITS-1:0]  lk_tag, fl_tag;

    assign lk_idx = lookup_pc[IDX_BITS-1:0];
    assign lk_tag = lookup_pc[ADDR_BITS-1:IDX_BITS];
    assign fl_idx = fill_pc[IDX_BITS-1:0];
    assign fl_tag = fill_pc[ADDR_BITS-1:IDX_BITS];

    // A lookup in the same cycle as an invalidate is forced to miss.
    assign hit      = valid[lk_idx] && (tags[lk_idx] == lk_tag) && !invalidate;
    assign hit_data = lines[lk_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= '0;
        end else if (invalidate) begin
            valid <= '0;
        end else if (fill_en) begin
            valid[fl_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en && !invalidate) begin
            tags[fl_idx]  <= fl_tag;
            lines[fl_idx] <= fill_data;
        end
    end

endmodule

// File: rtl/instruction_fetcher.sv
// Per-core fetch stage: reads one instruction from program memory over valid/ready.
// Define FETCH_ICACHE_EN to add a direct-mapped instruction cache in front of memory.
module instruction_fetcher #(
    parameter int PROGRAM_MEM_ADDR_BITS = gpu_pkg::PROGRAM_MEM_ADDR_BITS,
    parameter int PROGRAM_MEM_DATA_BITS = gpu_pkg::PROGRAM_MEM_DATA_BITS,
    parameter int ICACHE_DEPTH          = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    input  logic                             icache_invalidate,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);

    import gpu_pkg::*;

    fetcher_state_t                   state;
    logic                             cache_hit;
    logic [PROGRAM_MEM_DATA_BITS-1:0] cache_data;

    assign fetcher_state = state;

`ifdef FETCH_ICACHE_EN
    logic fill_en;

    assign fill_en = (state == FETCH_FETCHING) && mem_read_ready;

    fetch_icache #(
        .ADDR_BITS (PROGRAM_MEM_ADDR_BITS),
        .DATA_BITS (PROGRAM_MEM_DATA_BITS),
        .DEPTH     (ICACHE_DEPTH)
    ) u_icache (
        .clk        (clk),
        .reset      (reset),
        .lookup_pc  (current_pc),
        .fill_en    (fill_en),
        .fill_pc    (mem_read_address),
        .fill_data  (mem_read_data),
        .invalidate (icache_invalidate),
        .hit        (cache_hit),
        .hit_data   (cache_data)
    );
`else
    localparam int unused_icache_depth = ICACHE_DEPTH;
    logic unused_invalidate;

    assign unused_invalidate = icache_invalidate;
    assign cache_hit         = 1'b0;
    assign cache_data        = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= FETCH_IDLE;
            mem_read_valid   <= 1'b0;
            mem_read_address <= '0;
            instruction      <= '0;
        end else begin
            case (state)
                FETCH_IDLE: begin
                    if (core_state == CORE_FETCH) begin
                        mem_read_address <= current_pc;
                        if (cache_hit) begin
                            instruction <= cache_data;
                            state       <= FETCH_FETCHED;
                        end else begin
                            mem_read_valid <= 1'b1;
                            state          <= FETCH_FETCHING;
                        end
                    end
                end
                FETCH_FETCHING: begin
                    // Runs to completion even if the core leaves FETCH meanwhile.
                    if (mem_read_ready) begin
                        instruction    <= mem_read_data;
                        mem_read_valid <= 1'b0;
                        state          <= FETCH_FETCHED;
                    end
                end
                FETCH_FETCHED: begin
                    if (core_state == CORE_DECODE) begin
                        state <= FETCH_IDLE;
                    end
                end
                default: begin
                    mem_read_valid <= 1'b0;
                    state          <= FETCH_IDLE;
                end
            endcase
        end
    end

endmodule
